// File: rtl/omsp_atom_violation_log_pkg.sv
// Shared definitions for the atomicity-violation log: register offsets,
// cause and FSM encodings, and the record layout held in the log.
package omsp_atom_violation_log_pkg;

   localparam logic [2:0] ATOMV_CTRL    = 3'd0;
   localparam logic [2:0] ATOMV_STATUS  = 3'd1;
   localparam logic [2:0] ATOMV_HEAD_ID = 3'd2;
   localparam logic [2:0] ATOMV_HEAD_PC = 3'd3;
   localparam logic [2:0] ATOMV_POP     = 3'd4;
   localparam logic [2:0] ATOMV_TOTAL   = 3'd5;

   typedef enum logic [1:0] {
      CAUSE_UNKNOWN    = 2'd0,
      CAUSE_CLIX_NEST  = 2'd1,
      CAUSE_CLIX_BOUND = 2'd2,
      CAUSE_SM_NEST    = 2'd3
   } atomv_cause_e;

   typedef enum logic [1:0] {
      ATOMV_IDLE = 2'd0,
      ATOMV_REQ  = 2'd1,
      ATOMV_LOCK = 2'd2
   } atomv_state_e;

   typedef struct packed {
      logic [1:0]  cause;
      logic [15:0] id;
      logic [15:0] pc;
   } atomv_rec_t;

   localparam int ATOMV_REC_W = $bits(atomv_rec_t);

endpackage

// File: rtl/omsp_atomv_fifo.sv
// Circular record store for the violation log; a pop frees a slot for a
// push in the same cycle, a pop on empty is ignored.
module omsp_atomv_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 34,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic             mclk,
   input  logic             puc_rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge mclk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/omsp_atom_violation_log.sv
// Atomicity-violation log peripheral: records violations in a small FIFO,
// raises an interrupt and optionally a one-shot PUC request on a threshold.
module omsp_atom_violation_log
   import omsp_atom_violation_log_pkg::*;
#(
   parameter logic [14:0] BASE_ADDR = 15'h0190,
   parameter int          LOG_DEPTH = 4
) (
   input  logic        mclk,
   input  logic        puc_rst,
   input  logic        atom_violation,
   input  logic [1:0]  viol_cause,
   input  logic [15:0] sm_current_id,
   input  logic [15:0] pc,
   input  logic        per_en,
   input  logic [1:0]  per_we,
   input  logic [13:0] per_addr,
   input  logic [15:0] per_din,
   output logic [15:0] per_dout,
   output logic        irq_atomv,
   output logic        viol_reset_req
);

   localparam int CW = $clog2(LOG_DEPTH) + 1;

   logic         sel, wr, rd, pop_req;
   logic [2:0]   off;
   logic         irq_en_q, irq_en_d, rst_en_q, rst_en_d;
   logic [3:0]   thresh_q, thresh_d;
   logic         ovf_q, ovf_d, thr_hit_q, thr_hit_d, irq_q, irq_d;
   logic [15:0]  total_q, total_d;
   logic         fifo_full, fifo_empty, pop_ok, push_ok, ovf_set, thr_set;
   logic [CW-1:0] fifo_count, count_post;
   atomv_rec_t   rec_in, fifo_dout, head;
   atomv_state_e state_q, state_d;
   logic         unused_din;

   assign sel        = per_en & (per_addr[13:3] == BASE_ADDR[14:4]);
   assign off        = per_addr[2:0];
   assign wr         = sel & (|per_we);
   assign rd         = sel & ~(|per_we);
   assign pop_req    = wr & (off == ATOMV_POP);
   assign unused_din = ^{per_din[15:8], per_din[3:2]};

   assign rec_in = '{cause: viol_cause, id: sm_current_id, pc: pc};

   omsp_atomv_fifo #(.DEPTH(LOG_DEPTH), .WIDTH(ATOMV_REC_W)) u_fifo (
      .mclk    (mclk),
      .puc_rst (puc_rst),
      .push_i  (atom_violation),
      .pop_i   (pop_req),
      .din_i   (rec_in),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Mirror of the FIFO's accept rules, needed for the post-update count.
   assign pop_ok     = pop_req & ~fifo_empty;
   assign ovf_set    = atom_violation & fifo_full & ~pop_ok;
   assign push_ok    = atom_violation & ~ovf_set;
   assign count_post = fifo_count + CW'(push_ok) - CW'(pop_ok);
   assign head       = fifo_empty ? '0 : fifo_dout;

   always_comb begin
      state_d = state_q;
      thr_set = 1'b0;
      case (state_q)
         ATOMV_IDLE:
            if (thresh_q != 4'd0 && int'(count_post) >= int'(thresh_q)) begin
               state_d = ATOMV_REQ;
               thr_set = 1'b1;
            end
         ATOMV_REQ:  state_d = ATOMV_LOCK;
         ATOMV_LOCK: if (!thr_hit_q) state_d = ATOMV_IDLE;
         default:    state_d = ATOMV_IDLE;
      endcase
      if (!rst_en_q) begin
         state_d = ATOMV_IDLE;
         thr_set = 1'b0;
      end
   end

   always_comb begin
      irq_en_d  = irq_en_q;
      rst_en_d  = rst_en_q;
      thresh_d  = thresh_q;
      ovf_d     = ovf_q;
      thr_hit_d = thr_hit_q;
      total_d   = total_q;
      if (wr && off == ATOMV_CTRL && per_we[0]) begin
         irq_en_d = per_din[0];
         rst_en_d = per_din[1];
         thresh_d = per_din[7:4];
      end
      if (wr && off == ATOMV_STATUS && per_we[0]) begin
         if (per_din[4]) ovf_d     = 1'b0;
         if (per_din[5]) thr_hit_d = 1'b0;
      end
      // A new event wins over a simultaneous software clear.
      if (ovf_set) ovf_d     = 1'b1;
      if (thr_set) thr_hit_d = 1'b1;
      if (atom_violation && total_q != 16'hFFFF) total_d = total_q + 16'd1;
      irq_d = irq_en_q & ((fifo_count != '0) | ovf_q);
   end

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         irq_en_q  <= 1'b0;
         rst_en_q  <= 1'b0;
         thresh_q  <= 4'd0;
         ovf_q     <= 1'b0;
         thr_hit_q <= 1'b0;
         total_q   <= 16'd0;
         irq_q     <= 1'b0;
         state_q   <= ATOMV_IDLE;
      end else begin
         irq_en_q  <= irq_en_d;
         rst_en_q  <= rst_en_d;
         thresh_q  <= thresh_d;
         ovf_q     <= ovf_d;
         thr_hit_q <= thr_hit_d;
         total_q   <= total_d;
         irq_q     <= irq_d;
         state_q   <= state_d;
      end
   end

   assign irq_atomv      = irq_q;
   assign viol_reset_req = (state_q == ATOMV_REQ);

   always_comb begin
      per_dout = 16'h0000;
      if (rd) begin
         case (off)
            ATOMV_CTRL:    per_dout = {8'h00, thresh_q, 2'b00, rst_en_q, irq_en_q};
            ATOMV_STATUS:  per_dout = {6'h00, head.cause, 2'b00, thr_hit_q, ovf_q, 4'(fifo_count)};
            ATOMV_HEAD_ID: per_dout = head.id;
            ATOMV_HEAD_PC: per_dout = head.pc;
            ATOMV_TOTAL:   per_dout = total_q;
            default:       per_dout = 16'h0000;
         endcase
      end
   end

endmodule
